// File: rtl/intan_pkg.sv
// Shared definitions for the Intan frame packer: FSM states, default header and frame sizing.
package intan_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HEADER,
      ST_STAMP,
      ST_PAYLOAD,
      ST_DROP
   } state_e;

   localparam logic [31:0] HEADER_MAGIC_DEFAULT = 32'hC5A5_0001;

   // Two header words followed by two 16-bit samples per 32-bit payload word.
   function automatic int frame_words(input int samples_per_frame);
      return 2 + samples_per_frame / 2;
   endfunction

endpackage

// File: rtl/intan_frame_packer_if.sv
// Sample-stream input and downstream FIFO write bus of the frame packer.
interface intan_frame_packer_if;
   logic        sample_valid;
   logic [15:0] sample_data;
   logic [8:0]  fifo_count;
   logic        fifo_write_en;
   logic [31:0] fifo_write_data;

   modport master (
      output sample_valid, sample_data, fifo_count,
      input  fifo_write_en, fifo_write_data
   );

   modport slave (
      input  sample_valid, sample_data, fifo_count,
      output fifo_write_en, fifo_write_data
   );
endinterface

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at 16'hFFFF instead of wrapping.
module sat_counter16 (
   input  logic        clk,
   input  logic        rstn,
   input  logic        inc_i,
   output logic [15:0] count_o
);
   logic [15:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && count_q != 16'hFFFF) count_d = count_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!rstn) count_q <= 16'd0;
      else       count_q <= count_d;
   end

   assign count_o = count_q;
endmodule

// File: rtl/intan_frame_packer.sv
// Packs 16-bit samples into framed 32-bit FIFO words (magic, stamp, payload); drops whole
// frames when the downstream FIFO cannot hold them.
module intan_frame_packer
   import intan_pkg::*;
#(
   parameter int          SAMPLES_PER_FRAME = 64,
   parameter int          FIFO_DEPTH        = 256,
   parameter logic [31:0] HEADER_MAGIC      = HEADER_MAGIC_DEFAULT
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      enable,
   input  logic                      frame_start,
   intan_frame_packer_if.slave       bus,
   output logic [31:0]               frame_count,
   output logic [15:0]               drop_count,
   output logic [15:0]               err_count,
   output logic                      busy
);
   // Two spare entries of margin on top of the frame itself.
   localparam int          NEED_FREE = frame_words(SAMPLES_PER_FRAME) + 2;
   localparam logic [10:0] LAST_IDX  = 11'(SAMPLES_PER_FRAME - 1);

   state_e      state_q, state_d;
   logic [10:0] idx_q, idx_d;
   logic [15:0] held_q, held_d;
   logic [31:0] stamp_q, stamp_d;
   logic [31:0] frame_cnt_q, frame_cnt_d;
   logic        wen_q, wen_d;
   logic [31:0] wdata_q, wdata_d;
   logic        drop_inc, err_inc;
   logic        room;

   assign room = (FIFO_DEPTH - int'(bus.fifo_count)) >= NEED_FREE;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      held_d      = held_q;
      stamp_d     = stamp_q;
      frame_cnt_d = frame_cnt_q;
      wen_d       = 1'b0;
      wdata_d     = wdata_q;
      drop_inc    = 1'b0;
      err_inc     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.sample_valid) err_inc = 1'b1;
            if (frame_start && enable) begin
               frame_cnt_d = frame_cnt_q + 32'd1;
               stamp_d     = frame_cnt_q;
               idx_d       = 11'd0;
               if (room) begin
                  state_d = ST_HEADER;
               end else begin
                  state_d  = ST_DROP;
                  drop_inc = 1'b1;
               end
            end
         end
         ST_HEADER: begin
            err_inc = bus.sample_valid || (frame_start && enable);
            wen_d   = 1'b1;
            wdata_d = HEADER_MAGIC;
            state_d = ST_STAMP;
         end
         ST_STAMP: begin
            err_inc = bus.sample_valid || (frame_start && enable);
            wen_d   = 1'b1;
            wdata_d = stamp_q;
            state_d = ST_PAYLOAD;
         end
         ST_PAYLOAD, ST_DROP: begin
            err_inc = frame_start && enable;
            if (bus.sample_valid) begin
               // Dropped frames still consume their samples so the stream stays aligned.
               if (state_q == ST_PAYLOAD) begin
                  if (!idx_q[0]) begin
                     held_d = bus.sample_data;
                  end else begin
                     wen_d   = 1'b1;
                     wdata_d = {bus.sample_data, held_q};
                  end
               end
               if (idx_q == LAST_IDX) state_d = ST_IDLE;
               else                   idx_d   = idx_q + 11'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         idx_q       <= 11'd0;
         held_q      <= 16'd0;
         stamp_q     <= 32'd0;
         frame_cnt_q <= 32'd0;
         wen_q       <= 1'b0;
         wdata_q     <= 32'd0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         held_q      <= held_d;
         stamp_q     <= stamp_d;
         frame_cnt_q <= frame_cnt_d;
         wen_q       <= wen_d;
         wdata_q     <= wdata_d;
      end
   end

   sat_counter16 u_drop_cnt (
      .clk    (clk),
      .rstn   (rstn),
      .inc_i  (drop_inc),
      .count_o(drop_count)
   );

   sat_counter16 u_err_cnt (
      .clk    (clk),
      .rstn   (rstn),
      .inc_i  (err_inc),
      .count_o(err_count)
   );

   assign bus.fifo_write_en   = wen_q;
   assign bus.fifo_write_data = wdata_q;
   assign frame_count         = frame_cnt_q;
   assign busy                = (state_q != ST_IDLE);
endmodule

// File: tb/tb_intan_frame_packer.sv
// Bench for intan_frame_packer: directed scenarios plus random traffic against a frame-level model.
module tb_intan_frame_packer;
   localparam int          SPF   = 4;
   localparam int          DEPTH = 256;
   localparam logic [31:0] MAGIC = 32'hC5A5_0001;

   logic        clk = 1'b0;
   logic        rstn;
   logic        enable;
   logic        frame_start;
   logic [31:0] frame_count;
   logic [15:0] drop_count;
   logic [15:0] err_count;
   logic        busy;

   intan_frame_packer_if bus ();

   intan_frame_packer #(
      .SAMPLES_PER_FRAME(SPF),
      .FIFO_DEPTH       (DEPTH),
      .HEADER_MAGIC     (MAGIC)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .enable     (enable),
      .frame_start(frame_start),
      .bus        (bus),
      .frame_count(frame_count),
      .drop_count (drop_count),
      .err_count  (err_count),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Frame-level reference: is a frame open, is it being dropped, cycles since start, samples taken.
   logic        m_busy, m_drop;
   int          m_since, m_got;
   logic [31:0] m_fc, m_stamp;
   logic [15:0] m_dc, m_ec, m_half;
   logic [31:0] wlog[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   task automatic model_reset();
      m_busy = 1'b0; m_drop = 1'b0; m_since = 0; m_got = 0;
      m_fc = 32'd0; m_stamp = 32'd0; m_dc = 16'd0; m_ec = 16'd0; m_half = 16'd0;
   endtask

   task automatic do_reset();
      rstn = 1'b0; frame_start = 1'b0; enable = 1'b0;
      bus.sample_valid = 1'b0; bus.sample_data = 16'd0; bus.fifo_count = 9'd0;
      @(posedge clk); #1;
      model_reset();
      chk("rst_wen",   32'(bus.fifo_write_en), 32'd0);
      chk("rst_wdata", bus.fifo_write_data, 32'd0);
      chk("rst_fc",    frame_count, 32'd0);
      chk("rst_dc",    32'(drop_count), 32'd0);
      chk("rst_ec",    32'(err_count), 32'd0);
      chk("rst_busy",  32'(busy), 32'd0);
      rstn = 1'b1;
      wlog.delete();
   endtask

   task automatic cycle(input logic fs, input logic sv, input logic [15:0] sd,
                        input logic [8:0] fc, input logic en);
      logic        exp_wen, err;
      logic [31:0] exp_data;
      frame_start = fs; bus.sample_valid = sv; bus.sample_data = sd;
      bus.fifo_count = fc; enable = en;
      exp_wen = 1'b0; exp_data = 32'd0; err = 1'b0;
      if (!m_busy) begin
         if (sv) err = 1'b1;
         if (fs && en) begin
            m_busy = 1'b1; m_since = 0; m_got = 0;
            m_stamp = m_fc; m_fc = m_fc + 32'd1;
            m_drop = (DEPTH - int'(fc)) < (SPF / 2 + 4);
            if (m_drop) m_dc = sat_inc(m_dc);
         end
      end else begin
         if (fs && en) err = 1'b1;
         if (!m_drop && m_since == 0) begin
            exp_wen = 1'b1; exp_data = MAGIC;
         end else if (!m_drop && m_since == 1) begin
            exp_wen = 1'b1; exp_data = m_stamp;
         end
         if (sv) begin
            if (!m_drop && m_since < 2) begin
               err = 1'b1;
            end else begin
               if (!m_drop) begin
                  if (m_got % 2 == 0) m_half = sd;
                  else begin
                     exp_wen = 1'b1; exp_data = {sd, m_half};
                  end
               end
               m_got++;
               if (m_got == SPF) m_busy = 1'b0;
            end
         end
         m_since++;
      end
      if (err) m_ec = sat_inc(m_ec);
      @(posedge clk); #1;
      chk("wen", 32'(bus.fifo_write_en), 32'(exp_wen));
      if (exp_wen) chk("wdata", bus.fifo_write_data, exp_data);
      if (bus.fifo_write_en) wlog.push_back(bus.fifo_write_data);
      chk("frame_count", frame_count, m_fc);
      chk("drop_count", 32'(drop_count), 32'(m_dc));
      chk("err_count", 32'(err_count), 32'(m_ec));
      chk("busy", 32'(busy), 32'(m_busy));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'd0, 9'd0, 1'b1);
   endtask

   function automatic logic [31:0] logword(input int i);
      return (i < wlog.size()) ? wlog[i] : 32'hDEAD_BEEF;
   endfunction

   initial begin
      logic [31:0] exp31 [4];
      exp31[0] = 32'hC5A5_0001; exp31[1] = 32'h0000_0000;
      exp31[2] = 32'h0002_0001; exp31[3] = 32'h0004_0003;
      model_reset();
      do_reset();

      // Basic frame with back-to-back samples.
      cycle(1'b1, 1'b0, 16'd0, 9'd0, 1'b1);
      idle(2);
      for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b1, 16'(i), 9'd0, 1'b1);
      idle(2);
      chk("r031_nwords", 32'(wlog.size()), 32'd4);
      for (int i = 0; i < 4; i++) chk("r031_word", logword(i), exp31[i]);
      chk("r031_fc", frame_count, 32'd1);

      // Not enough room: whole frame dropped.
      do_reset();
      cycle(1'b1, 1'b0, 16'd0, 9'd253, 1'b1);
      for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b1, 16'(i), 9'd253, 1'b1);
      chk("r032_busy", 32'(busy), 32'd0);
      chk("r032_dc", 32'(drop_count), 32'd1);
      chk("r032_fc", frame_count, 32'd1);
      chk("r032_nwords", 32'(wlog.size()), 32'd0);

      // Sample during HEADER is an error and not part of the frame.
      do_reset();
      cycle(1'b1, 1'b0, 16'd0, 9'd0, 1'b1);
      cycle(1'b0, 1'b1, 16'hAAAA, 9'd0, 1'b1);
      idle(1);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 16'h0010 + 16'(i), 9'd0, 1'b1);
      chk("r033_busy", 32'(busy), 32'd1);
      cycle(1'b0, 1'b1, 16'h0013, 9'd0, 1'b1);
      chk("r033_ec", 32'(err_count), 32'd1);
      chk("r033_w2", logword(2), 32'h0011_0010);

      // frame_start during PAYLOAD.
      do_reset();
      cycle(1'b1, 1'b0, 16'd0, 9'd0, 1'b1);
      idle(2);
      cycle(1'b0, 1'b1, 16'h0101, 9'd0, 1'b1);
      cycle(1'b0, 1'b1, 16'h0202, 9'd0, 1'b1);
      cycle(1'b1, 1'b0, 16'd0, 9'd0, 1'b1);
      cycle(1'b0, 1'b1, 16'h0303, 9'd0, 1'b1);
      cycle(1'b0, 1'b1, 16'h0404, 9'd0, 1'b1);
      chk("r034_ec", 32'(err_count), 32'd1);
      chk("r034_nwords", 32'(wlog.size()), 32'd4);
      chk("r034_w3", logword(3), 32'h0404_0303);
      chk("r034_fc", frame_count, 32'd1);

      // Simultaneous start and sample in IDLE; enable dropping mid-frame; start while disabled.
      do_reset();
      cycle(1'b1, 1'b1, 16'h5555, 9'd0, 1'b1);
      chk("r025_ec", 32'(err_count), 32'd1);
      chk("r025_busy", 32'(busy), 32'd1);
      idle(2);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 16'(i), 9'd0, 1'b0);
      chk("r023_nwords", 32'(wlog.size()), 32'd4);
      cycle(1'b1, 1'b0, 16'd0, 9'd0, 1'b0);
      chk("r023_fc", frame_count, 32'd1);

      // Boundary: free space exactly FRAME_WORDS+2 accepts, one less drops.
      do_reset();
      cycle(1'b1, 1'b0, 16'd0, 9'd250, 1'b1);
      idle(2);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 16'(i), 9'd250, 1'b1);
      cycle(1'b1, 1'b0, 16'd0, 9'd251, 1'b1);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 16'(i), 9'd251, 1'b1);
      chk("room_nwords", 32'(wlog.size()), 32'd4);
      chk("room_dc", 32'(drop_count), 32'd1);

      // Reset mid-frame abandons it; next frame stamps from zero.
      do_reset();
      cycle(1'b1, 1'b0, 16'd0, 9'd0, 1'b1);
      idle(2);
      cycle(1'b0, 1'b1, 16'h0A0A, 9'd0, 1'b1);
      do_reset();
      idle(4);
      chk("r035_nwords", 32'(wlog.size()), 32'd0);
      cycle(1'b1, 1'b0, 16'd0, 9'd0, 1'b1);
      idle(2);
      chk("r035_stamp", logword(1), 32'd0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 16'(i), 9'd0, 1'b1);

      // Random traffic.
      do_reset();
      for (int n = 0; n < 2000; n++) begin
         logic       fs, sv, en;
         logic [8:0] fc;
         fs = ($urandom_range(0, 11) == 0);
         sv = fs ? 1'b0 : ($urandom_range(0, 2) != 0);
         en = ($urandom_range(0, 9) != 0);
         case ($urandom_range(0, 4))
            0:       fc = 9'd0;
            1:       fc = 9'd250;
            2:       fc = 9'd251;
            3:       fc = 9'd253;
            default: fc = 9'($urandom_range(0, 299));
         endcase
         cycle(fs, sv, 16'($urandom), fc, en);
      end
      for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 16'($urandom), 9'd0, 1'b1);

      // err_count saturation.
      do_reset();
      for (int i = 0; i < 65537; i++) cycle(1'b0, 1'b1, 16'd0, 9'd0, 1'b1);
      chk("r036_ec", 32'(err_count), 32'h0000_FFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/intan_frame_packer.md
INTAN_FRAME_PACKER -- requirements
Module: intan_frame_packer

Interface
REQ-001 SHALL have parameter SAMPLES_PER_FRAME, default 64, meaning 16-bit samples per frame (even, 2..1024).
REQ-002 SHALL have parameter FIFO_DEPTH, default 256, meaning entries in the downstream FIFO.
REQ-003 SHALL have parameter HEADER_MAGIC, default 32'hC5A5_0001, meaning the first word of every frame.
REQ-004 SHALL have port clk, input, 1, clock; reset rstn, synchronous, active-low; clock clk.
REQ-005 SHALL have port rstn, input, 1, synchronous active-low reset.
REQ-006 SHALL have port enable, input, 1, accept new frames while high.
REQ-007 SHALL have port frame_start, input, 1, single-cycle pulse marking the start of a sampling period.
REQ-008 SHALL have ports sample_valid (input, 1) and sample_data (input, 16), one sample per valid cycle.
REQ-009 SHALL have port fifo_count, input, 9, downstream FIFO occupancy.
REQ-010 SHALL have ports fifo_write_en (output, 1) and fifo_write_data (output, 32), registered.
REQ-011 SHALL have ports frame_count (output, 32), drop_count (output, 16), err_count (output, 16), busy (output, 1).

Function
REQ-012 FRAME_WORDS SHALL equal 2 + SAMPLES_PER_FRAME/2; frame layout: HEADER_MAGIC, frame_count snapshot, payload words.
REQ-013 FSM states SHALL be IDLE, HEADER, STAMP, PAYLOAD, DROP; busy SHALL be high outside IDLE.
REQ-014 In IDLE, frame_start with enable high SHALL increment frame_count (32-bit wrap) and latch the pre-increment value as the stamp.
REQ-015 At that frame_start, if FIFO_DEPTH - fifo_count >= FRAME_WORDS + 2, SHALL go to HEADER; otherwise SHALL go to DROP and increment drop_count.
REQ-016 HEADER SHALL write HEADER_MAGIC for one cycle then go to STAMP; STAMP SHALL write the latched stamp for one cycle then go to PAYLOAD.
REQ-017 In PAYLOAD, even-indexed samples SHALL be held in a 16-bit register; each odd-indexed sample SHALL produce one write {sample_data, held} (first sample in bits 15:0).
REQ-018 fifo_write_en SHALL assert exactly one cycle after the accepting edge (HEADER/STAMP state entry or odd sample), with data valid in the same cycle.
REQ-019 After the write of sample SAMPLES_PER_FRAME-1, SHALL return to IDLE; back-to-back sample_valid SHALL be sustained at one per cycle.
REQ-020 DROP SHALL consume SAMPLES_PER_FRAME valid samples without writing, then return to IDLE.
REQ-021 sample_valid in IDLE, HEADER or STAMP SHALL be discarded and SHALL increment err_count.
REQ-022 frame_start outside IDLE SHALL be ignored, SHALL increment err_count, and SHALL NOT alter the current frame.
REQ-023 frame_start with enable low SHALL be ignored with no counter change; enable falling mid-frame SHALL let the frame complete.
REQ-024 drop_count and err_count SHALL saturate at 16'hFFFF; frame_count wraps.
REQ-025 Simultaneous sample_valid and frame_start in IDLE SHALL start the frame and count the sample as an error.
REQ-026 The block SHALL never write a partial frame; FIFO-full behaviour downstream SHALL never be triggered when fifo_count is accurate.

Reset
REQ-027 On rstn low at a clk edge, state SHALL be IDLE, fifo_write_en 0, fifo_write_data 0, all counters 0, busy 0, held sample 0.
REQ-028 Reset mid-frame SHALL abandon the frame; no further writes for it SHALL occur.

Structure
REQ-029 A shared package intan_pkg SHALL hold the FSM state enum, HEADER_MAGIC default and the FRAME_WORDS function.
REQ-030 The saturating 16-bit counter SHALL be one sub-module, sat_counter16, instantiated twice.

Verification (SAMPLES_PER_FRAME=4, FIFO_DEPTH=256)
REQ-031 fifo_count=0, frame_start, 4 back-to-back samples 0x0001..0x0004 -> writes C5A50001, 00000000, 00020001, 00040003 on consecutive write cycles; frame_count=1.
REQ-032 fifo_count=253 (free 3 < 6), frame_start, 4 samples -> no writes, drop_count=1, frame_count=1, busy low after 4th sample.
REQ-033 sample_valid in cycle after frame_start -> err_count=1, sample discarded, frame still needs 4 more samples.
REQ-034 frame_start during PAYLOAD -> err_count=1, current frame emits 4 words unchanged.
REQ-035 rstn low after second payload word -> no further writes, all outputs 0; next frame stamp=0.
REQ-036 err_count preloaded by 65536 protocol errors -> holds 16'hFFFF.
